// File: rtl/rng_pkg.sv
// rng_pkg: shared LFSR constants, tap positions, FSM states and LFSR step for rng_arbiter
package rng_pkg;
   localparam int LFSR_W = 13;
   localparam logic [LFSR_W-1:0] RESET_SEED = 13'h000F;
   localparam int TAP_A = 12;
   localparam int TAP_B = 3;
   localparam int TAP_C = 2;
   localparam int TAP_D = 0;
   localparam logic [3:0] FILL_LAST = 4'd12;
   typedef enum logic [1:0] {FILL, READY, GRANT} state_t;
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D]};
   endfunction
endpackage

// File: rtl/lfsr13.sv
// lfsr13: 13-bit Fibonacci LFSR with shift-enable and synchronous load (load wins)
module lfsr13
   import rng_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              i_en,
   input  logic              i_ld,
   input  logic [LFSR_W-1:0] i_ld_val,
   output logic [LFSR_W-1:0] o_state
);
   logic [LFSR_W-1:0] r_state;
   // load has priority over shifting so a reseed never loses to an in-flight fill
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= RESET_SEED;
      else r_state <= i_ld ? i_ld_val : i_en ? lfsr_step(r_state) : r_state;
   end
   assign o_state = r_state;
endmodule

// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin distribution of 13-bit LFSR words; optional repeat check via RNG_HEALTH_EN
module rng_arbiter
   import rng_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req,
   input  logic              seed_ld,
   input  logic [LFSR_W-1:0] seed,
   output logic [NREQ-1:0]   gnt,
   output logic [LFSR_W-1:0] rnd,
   output logic              rnd_vld,
   output logic              busy,
   output logic              health_err
);
   localparam int PW = $clog2(NREQ);
   state_t            r_state, w_state_nx;
   logic [3:0]        r_cnt;
   logic [PW-1:0]     r_ptr, w_idx, w_j;
   logic [LFSR_W-1:0] r_buf, r_rnd, w_lfsr, w_lfsr_nx, w_seed;
   logic [NREQ-1:0]   r_gnt;
   logic              r_vld, w_fill_done, w_grant;

   assign w_seed      = (seed == '0) ? RESET_SEED : seed;
   assign w_lfsr_nx   = lfsr_step(w_lfsr);
   assign w_fill_done = (r_state == FILL) && (r_cnt == FILL_LAST) && !seed_ld;
   assign w_grant     = (r_state == READY) && (|req) && !seed_ld;

   lfsr13 u_lfsr (
      .clock    (clock),
      .reset_n  (reset_n),
      .i_en     (r_state == FILL),
      .i_ld     (seed_ld),
      .i_ld_val (w_seed),
      .o_state  (w_lfsr)
   );

   // round-robin search: first asserted req at or after the priority pointer
   always_comb begin
      w_idx = r_ptr;
      w_j   = r_ptr;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (req[w_j] && !req[w_idx]) ? w_j : w_idx;
         w_j   = (w_j == PW'(NREQ - 1)) ? '0 : w_j + 1'b1;
      end
   end

   // next state: reseed always restarts the fill, even over a pending grant
   always_comb begin
      w_state_nx = seed_ld ? FILL : w_fill_done ? READY : w_grant ? GRANT :
                   (r_state == GRANT) ? FILL : r_state;
   end

   // state register
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= FILL;
      else r_state <= w_state_nx;
   end

   // fill counter, word buffer, pointer and registered grant outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
         r_ptr <= '0;
         r_buf <= '0;
         r_gnt <= '0;
         r_rnd <= '0;
         r_vld <= 1'b0;
      end else begin
         r_cnt <= (r_state == FILL && !seed_ld && !w_fill_done) ? r_cnt + 4'd1 : '0;
         r_buf <= w_fill_done ? w_lfsr_nx : r_buf;
         r_gnt <= w_grant ? NREQ'(1) << w_idx : '0;
         r_rnd <= w_grant ? r_buf : r_rnd;
         r_vld <= w_grant;
         r_ptr <= !w_grant ? r_ptr : (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      end
   end

`ifdef RNG_HEALTH_EN
   logic [LFSR_W-1:0] r_prev;
   logic              r_match, r_health;
   // flag a freshly filled word equal to the previous one; sticky until reset
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_prev   <= '0;
         r_match  <= 1'b0;
         r_health <= 1'b0;
      end else begin
         r_prev   <= w_fill_done ? w_lfsr_nx : r_prev;
         r_match  <= w_fill_done && (w_lfsr_nx == r_prev);
         r_health <= r_health | r_match;
      end
   end
   assign health_err = r_health;
`else
   assign health_err = 1'b0;
`endif

   assign gnt     = r_gnt;
   assign rnd     = r_rnd;
   assign rnd_vld = r_vld;
   assign busy    = (r_state == FILL);
endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: directed and random checks of rng_arbiter against a behavioural model
module tb_rng_arbiter;
   localparam int NREQ = 4;
   logic        clock = 1'b0, reset_n = 1'b0, seed_ld = 1'b0;
   logic [3:0]  req = '0;
   logic [12:0] seed = '0;
   logic [3:0]  gnt;
   logic [12:0] rnd;
   logic        rnd_vld, busy, health_err;
   int n_vec = 0, n_err = 0, cyc = 0;

   rng_arbiter #(.NREQ(NREQ)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .seed_ld(seed_ld), .seed(seed),
      .gnt(gnt), .rnd(rnd), .rnd_vld(rnd_vld), .busy(busy), .health_err(health_err)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
      end
   endtask

   // model: words become available after 13 shifts; a grant consumes the word
   int m_lfsr, m_word, m_ptr, m_shifts, m_prev;
   bit m_avail, m_granting, m_match, m_health, e_vld;
   int e_gnt, e_rnd;

   function automatic int step(int s);
      int fb;
      fb = ((s >> 12) ^ (s >> 3) ^ (s >> 2) ^ s) & 1;
      return ((s << 1) | fb) & 'h1FFF;
   endfunction

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_lfsr = 'hF; m_word = 0; m_ptr = 0; m_shifts = 0; m_prev = 0;
         m_avail = 0; m_granting = 0; m_match = 0; m_health = 0;
         e_gnt = 0; e_rnd = 0; e_vld = 0;
      end else begin
         m_health = m_health | m_match;
         m_match = 0;
         e_gnt = 0;
         e_vld = 0;
         if (seed_ld) begin
            m_lfsr = (seed == 0) ? 'hF : int'(seed);
            m_shifts = 0; m_avail = 0; m_granting = 0;
         end else if (m_granting) begin
            m_granting = 0; m_shifts = 0;
         end else if (m_avail) begin
            if (req != 0) begin
               for (int k = 0; k < NREQ; k++) begin
                  int i;
                  i = (m_ptr + k) % NREQ;
                  if (req[i]) begin
                     e_gnt = 1 << i;
                     m_ptr = (i + 1) % NREQ;
                     break;
                  end
               end
               e_rnd = m_word; e_vld = 1; m_avail = 0; m_granting = 1;
            end
         end else begin
            m_lfsr = step(m_lfsr);
            m_shifts++;
            if (m_shifts == 13) begin
               m_word = m_lfsr; m_avail = 1;
               m_match = (m_word == m_prev);
               m_prev = m_word;
            end
         end
      end
   end

   // cycle-by-cycle comparison against the model
   always @(negedge clock) if (reset_n) begin
      chk("gnt", gnt, e_gnt);
      chk("rnd", rnd, e_rnd);
      chk("rnd_vld", rnd_vld, e_vld);
      chk("busy", busy, (m_avail || m_granting) ? 0 : 1);
`ifdef RNG_HEALTH_EN
      chk("health_err", health_err, m_health);
`else
      chk("health_err", health_err, 0);
`endif
   end

   task automatic wait_gnt(output int g, output int t);
      g = 0;
      t = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (gnt != 0) begin
            g = gnt;
            t = cyc;
            return;
         end
      end
      chk("gnt_timeout", 0, 1);
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (!busy && !rnd_vld) return;
      end
      chk("ready_timeout", 0, 1);
   endtask

   int g, t, t0;
   int exp_seq[5] = '{1, 2, 4, 8, 1};

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_gnt", gnt, 0);
      chk("rst_rnd", rnd, 0);
      chk("rst_vld", rnd_vld, 0);
      chk("rst_busy", busy, 1);
      chk("rst_health", health_err, 0);
      // first word after reset
      @(negedge clock);
      reset_n = 1'b1;
      req = 4'b0001;
      repeat (12) @(negedge clock);
      chk("busy_12", busy, 1);
      @(negedge clock);
      chk("busy_13", busy, 0);
      @(negedge clock);
      chk("first_gnt", gnt, 4'b0001);
      chk("first_rnd", rnd, 'h1FF4);
      chk("first_vld", rnd_vld, 1);
      @(negedge clock);
      chk("gnt_pulse", gnt, 0);
      chk("rnd_held", rnd, 'h1FF4);
      // all requesters held: strict rotation 15 cycles apart
      reset_n = 1'b0;
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      req = 4'b1111;
      t0 = cyc;
      for (int n = 0; n < 5; n++) begin
         wait_gnt(g, t);
         chk("rr_gnt", g, exp_seq[n]);
         chk("rr_time", t - t0, (n == 0) ? 14 : 15);
         t0 = t;
      end
      // reseed with zero mid-fill
      req = 4'b0010;
      repeat (5) @(negedge clock);
      seed_ld = 1'b1;
      seed = '0;
      @(negedge clock);
      seed_ld = 1'b0;
      t0 = cyc;
      wait_gnt(g, t);
      chk("seed0_dt", t - t0, 14);
      chk("seed0_rnd", rnd, 'h1FF4);
      chk("seed0_gnt", g, 4'b0010);
      // reseed on the same edge READY would grant
      req = 4'b0000;
      wait_ready();
      req = 4'b0100;
      seed_ld = 1'b1;
      seed = 13'h0ABC;
      @(negedge clock);
      chk("seed_blocks_gnt", gnt, 0);
      chk("seed_busy", busy, 1);
      seed_ld = 1'b0;
      t0 = cyc;
      wait_gnt(g, t);
      chk("seed_ready_gnt", g, 4'b0100);
      chk("seed_ready_dt", t - t0, 14);
      // random traffic with occasional reseeds
      for (int i = 0; i < 1500; i++) begin
         @(negedge clock);
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         seed_ld = ($urandom_range(0, 39) == 0);
         seed = ($urandom_range(0, 3) == 0) ? 13'h0 : 13'($urandom);
      end
      @(negedge clock);
      seed_ld = 1'b0;
      req = 4'b1111;
      // asynchronous reset during GRANT
      wait_gnt(g, t);
      #2 reset_n = 1'b0;
      #1;
      chk("async_gnt", gnt, 0);
      chk("async_vld", rnd_vld, 0);
      chk("async_rnd", rnd, 0);
      chk("async_busy", busy, 1);
      @(negedge clock);
      reset_n = 1'b1;
      t0 = cyc;
      wait_gnt(g, t);
      chk("ptr_reset_gnt", g, 4'b0001);
      chk("ptr_reset_dt", t - t0, 14);
      chk("ptr_reset_rnd", rnd, 'h1FF4);
      // reseed to the reset value repeats the last word
      req = 4'b0000;
      @(negedge clock);
      seed_ld = 1'b1;
      seed = 13'h000F;
      @(negedge clock);
      seed_ld = 1'b0;
      req = 4'b0001;
      wait_gnt(g, t);
      chk("repeat_rnd", rnd, 'h1FF4);
`ifdef RNG_HEALTH_EN
      chk("health_set", health_err, 1);
      req = 4'b0000;
      seed_ld = 1'b1;
      seed = 13'h0123;
      @(negedge clock);
      seed_ld = 1'b0;
      repeat (20) @(negedge clock);
      chk("health_sticky", health_err, 1);
`else
      chk("health_off", health_err, 0);
`endif
      reset_n = 1'b0;
      #1;
      chk("health_reset", health_err, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
